// File: rtl/cordic_access_arbiter_pkg.sv
// rtl/cordic_access_arbiter_pkg.sv - shared sizes, client codes and FSM state type for the CORDIC arbiter
//
// Purpose: the constants here are shared with the CORDIC input mux, which
// decodes `block` with the same CLIENT_* codes. Keep both in step.

package cordic_access_arbiter_pkg;

    localparam int NUM_CLIENTS = 6;
    localparam int SEL_WIDTH   = 3;

    // Client index == mux `block` code.
    localparam logic [SEL_WIDTH-1:0] CLIENT_GSO   = 3'd0;
    localparam logic [SEL_WIDTH-1:0] CLIENT_NORM  = 3'd1;
    localparam logic [SEL_WIDTH-1:0] CLIENT_UPDT  = 3'd2;
    localparam logic [SEL_WIDTH-1:0] CLIENT_EST   = 3'd3;
    localparam logic [SEL_WIDTH-1:0] CLIENT_CONV  = 3'd4;
    localparam logic [SEL_WIDTH-1:0] CLIENT_THETA = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_HOLDOFF = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cordic_access_arbiter_if.sv
// rtl/cordic_access_arbiter_if.sv - request/grant/done bundle between the clients and the CORDIC arbiter
//
// Signals:
//   en              arbitration enable (gates new grants only)
//   req             level request per client
//   release_pulse   one-cycle release pulse per client ("release" is a reserved word)
//   cordic_vec_done vectoring-mode done pulse from the CORDIC
//   cordic_rot_done rotation-mode done pulse from the CORDIC
//   grant           one-hot ownership
//   block           CORDIC mux select
//   mux_en          CORDIC mux enable
//   busy            high while any client owns the CORDIC
//   vec_done_out    vectoring done routed to the owner
//   rot_done_out    rotation done routed to the owner
//   timeout_err     one-cycle pulse on watchdog revoke
//   timeout_client  last revoked owner
// Modports: master = client side / environment, slave = arbiter.

interface cordic_access_arbiter_if;
    import cordic_access_arbiter_pkg::*;

    logic                   en;
    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] release_pulse;
    logic                   cordic_vec_done;
    logic                   cordic_rot_done;
    logic [NUM_CLIENTS-1:0] grant;
    logic [SEL_WIDTH-1:0]   block;
    logic                   mux_en;
    logic                   busy;
    logic [NUM_CLIENTS-1:0] vec_done_out;
    logic [NUM_CLIENTS-1:0] rot_done_out;
    logic                   timeout_err;
    logic [SEL_WIDTH-1:0]   timeout_client;

    modport master (
        output en, req, release_pulse, cordic_vec_done, cordic_rot_done,
        input  grant, block, mux_en, busy, vec_done_out, rot_done_out,
               timeout_err, timeout_client
    );

    modport slave (
        input  en, req, release_pulse, cordic_vec_done, cordic_rot_done,
        output grant, block, mux_en, busy, vec_done_out, rot_done_out,
               timeout_err, timeout_client
    );

endinterface

// File: rtl/cordic_access_arbiter_rr_priority_picker.sv
// rtl/cordic_access_arbiter_rr_priority_picker.sv - combinational round-robin winner search
//
// Ports:
//   req        in  request vector
//   last_owner in  index of the previous owner; search starts just above it
//   winner     out index of the first requester found, wrapping at NUM_CLIENTS
//   valid      out at least one request present

module rr_priority_picker
    import cordic_access_arbiter_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [SEL_WIDTH-1:0]   last_owner,
    output logic [SEL_WIDTH-1:0]   winner,
    output logic                   valid
);

    // Scan from the farthest offset down to the nearest so the requester
    // closest above last_owner is the last one written, hence the winner.
    // last_owner itself sits at offset NUM_CLIENTS, i.e. lowest priority.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = NUM_CLIENTS; off >= 1; off--) begin
            int idx;
            idx = (int'(last_owner) + off) % NUM_CLIENTS;
            if (req[idx]) begin
                winner = SEL_WIDTH'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_access_arbiter.sv
// rtl/cordic_access_arbiter.sv - round-robin CORDIC ownership arbiter with done routing and watchdog
//
// Ports:
//   clk   in  system clock
//   nrst  in  asynchronous active-low reset
//   bus   slave side of cordic_access_arbiter_if (requests, releases, CORDIC
//         done pulses in; grant/block/mux_en/busy, routed dones, watchdog out)
// Parameter TIMEOUT_CYCLES: OWN cycles without a done pulse before revoke.

module cordic_access_arbiter
    import cordic_access_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    nrst,
    cordic_access_arbiter_if.slave  bus
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_n;
    logic [NUM_CLIENTS-1:0] grant_q, grant_n;
    logic [SEL_WIDTH-1:0]   block_q, block_n;
    logic                   mux_en_q, mux_en_n;
    logic [SEL_WIDTH-1:0]   last_owner_q, last_owner_n;
    logic [WD_W-1:0]        wd_q, wd_n;
    logic                   terr_q, terr_n;
    logic [SEL_WIDTH-1:0]   tclient_q, tclient_n;

    logic [SEL_WIDTH-1:0]   pick_winner;
    logic                   pick_valid;
    logic                   rel_hit;
    logic                   done_any;

    rr_priority_picker u_picker (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Only the owner's release bit counts; grant is zero outside OWN.
    assign rel_hit  = |(bus.release_pulse & grant_q);
    assign done_any = bus.cordic_vec_done | bus.cordic_rot_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            block_q      <= CLIENT_GSO;
            mux_en_q     <= 1'b0;
            last_owner_q <= CLIENT_THETA;   // client 0 wins the first round
            wd_q         <= '0;
            terr_q       <= 1'b0;
            tclient_q    <= '0;
        end else begin
            state_q      <= state_n;
            grant_q      <= grant_n;
            block_q      <= block_n;
            mux_en_q     <= mux_en_n;
            last_owner_q <= last_owner_n;
            wd_q         <= wd_n;
            terr_q       <= terr_n;
            tclient_q    <= tclient_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        grant_n      = grant_q;
        block_n      = block_q;
        mux_en_n     = mux_en_q;
        last_owner_n = last_owner_q;
        wd_n         = wd_q;
        terr_n       = 1'b0;
        tclient_n    = tclient_q;

        case (state_q)
            // last_owner already holds the previous owner when HOLDOFF is
            // entered, so IDLE and HOLDOFF arbitrate identically; HOLDOFF
            // just never lingers, which gives exactly one dead cycle.
            ST_IDLE, ST_HOLDOFF: begin
                grant_n  = '0;
                mux_en_n = 1'b0;
                state_n  = ST_IDLE;
                if (bus.en && pick_valid) begin
                    state_n  = ST_OWN;
                    grant_n  = NUM_CLIENTS'(1) << pick_winner;
                    block_n  = pick_winner;
                    mux_en_n = 1'b1;
                    wd_n     = '0;
                end
            end

            ST_OWN: begin
                if (rel_hit) begin
                    state_n      = ST_HOLDOFF;
                    grant_n      = '0;
                    mux_en_n     = 1'b0;
                    last_owner_n = block_q;
                end else if (done_any) begin
                    wd_n = '0;
                end else if (wd_q == WD_LAST) begin
                    state_n      = ST_HOLDOFF;
                    grant_n      = '0;
                    mux_en_n     = 1'b0;
                    last_owner_n = block_q;
                    terr_n       = 1'b1;
                    tclient_n    = block_q;
                end else if (wd_q != '1) begin
                    wd_n = wd_q + 1'b1;
                end
            end

            default: begin
                state_n  = ST_IDLE;
                grant_n  = '0;
                mux_en_n = 1'b0;
            end
        endcase
    end

    assign bus.grant          = grant_q;
    assign bus.block          = block_q;
    assign bus.mux_en         = mux_en_q;
    assign bus.busy           = mux_en_q;
    assign bus.vec_done_out   = grant_q & {NUM_CLIENTS{bus.cordic_vec_done}};
    assign bus.rot_done_out   = grant_q & {NUM_CLIENTS{bus.cordic_rot_done}};
    assign bus.timeout_err    = terr_q;
    assign bus.timeout_client = tclient_q;

endmodule

// File: tb/tb_cordic_access_arbiter.sv
// tb/tb_cordic_access_arbiter.sv - self-checking bench for cordic_access_arbiter

module tb_cordic_access_arbiter;
    import cordic_access_arbiter_pkg::*;

    localparam int TO = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    cordic_access_arbiter_if bus();

    cordic_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: who owns the CORDIC, whose turn is next, watchdog age.
    int m_owner;
    int m_last;
    int m_block;
    int m_wd;
    int m_tc;
    bit m_terr;

    function automatic int rr_pick(input logic [5:0] r, input int last);
        for (int k = 1; k <= NUM_CLIENTS; k++)
            if (r[(last + k) % NUM_CLIENTS]) return (last + k) % NUM_CLIENTS;
        return -1;
    endfunction

    function automatic logic [5:0] exp_grant();
        return (m_owner >= 0) ? (6'd1 << m_owner) : 6'd0;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = NUM_CLIENTS - 1; m_block = 0;
        m_wd = 0; m_tc = 0; m_terr = 0;
    endtask

    task automatic model_step();
        m_terr = 0;
        if (m_owner >= 0) begin
            if (bus.release_pulse[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end else if (bus.cordic_vec_done || bus.cordic_rot_done) begin
                m_wd = 0;
            end else if (m_wd == TO - 1) begin
                m_terr = 1; m_tc = m_block; m_last = m_owner; m_owner = -1;
            end else begin
                m_wd++;
            end
        end else if (bus.en && bus.req != 0) begin
            m_owner = rr_pick(bus.req, m_last);
            m_block = m_owner;
            m_wd    = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.en = 1'b1; bus.req = '0; bus.release_pulse = '0;
        bus.cordic_vec_done = 1'b0; bus.cordic_rot_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        n_total++;
        if ({bus.grant, bus.block, bus.mux_en, bus.busy} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs grant=%b block=%0d mux_en=%b busy=%b want all 0",
                     bus.grant, bus.block, bus.mux_en, bus.busy);
        end
        n_total++;
        if ({bus.timeout_err, bus.timeout_client} !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_timeout err=%b client=%0d want 0/0", bus.timeout_err, bus.timeout_client);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_first_grant();
        do_reset();
        bus.req = 6'b000010;
        cyc();
        n_total++;
        if ({bus.grant, bus.block, bus.mux_en, bus.busy} !== {6'b000010, 3'd1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL first_grant grant=%b block=%0d mux_en=%b busy=%b want 000010/1/1/1",
                     bus.grant, bus.block, bus.mux_en, bus.busy);
        end
    endtask

    task automatic test_release_handover();
        do_reset();
        bus.req = 6'b100001;
        cyc();
        n_total++;
        if (bus.grant !== 6'b000001) begin
            n_bad++;
            $display("FAIL priority_after_reset grant=%b want 000001", bus.grant);
        end
        bus.release_pulse = 6'b000001;
        cyc();
        bus.release_pulse = '0;
        n_total++;
        if ({bus.grant, bus.mux_en, bus.busy} !== 8'd0) begin
            n_bad++;
            $display("FAIL holdoff_dead grant=%b mux_en=%b busy=%b want 0", bus.grant, bus.mux_en, bus.busy);
        end
        cyc();
        n_total++;
        if ({bus.grant, bus.block} !== {6'b100000, 3'd5}) begin
            n_bad++;
            $display("FAIL handover_to_5 grant=%b block=%0d want 100000/5", bus.grant, bus.block);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 6'b111111;
        cyc();
        for (int k = 0; k <= NUM_CLIENTS; k++) begin
            logic [5:0] want;
            want = 6'd1 << (k % NUM_CLIENTS);
            for (int c = 0; c < 3; c++) begin
                n_total++;
                if (bus.grant !== want || bus.mux_en !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rr_order k=%0d c=%0d grant=%b mux_en=%b want %b/1", k, c, bus.grant, bus.mux_en, want);
                end
                if (c == 2) bus.release_pulse = want;
                cyc();
            end
            bus.release_pulse = '0;
            n_total++;
            if (bus.grant !== 6'd0 || bus.mux_en !== 1'b0) begin
                n_bad++;
                $display("FAIL rr_dead_cycle k=%0d grant=%b mux_en=%b want 0/0", k, bus.grant, bus.mux_en);
            end
            cyc();
        end
    endtask

    task automatic test_done_routing();
        do_reset();
        bus.req = 6'b001000;
        cyc();
        bus.cordic_vec_done = 1'b1;
        #1;
        n_total++;
        if ({bus.vec_done_out, bus.rot_done_out} !== {6'b001000, 6'b000000}) begin
            n_bad++;
            $display("FAIL vec_done_route vec=%b rot=%b want 001000/000000", bus.vec_done_out, bus.rot_done_out);
        end
        bus.cordic_vec_done = 1'b0;
        bus.release_pulse = 6'b000010;
        cyc();
        bus.release_pulse = '0;
        n_total++;
        if (bus.grant !== 6'b001000) begin
            n_bad++;
            $display("FAIL nonowner_release grant=%b want 001000", bus.grant);
        end
        bus.release_pulse = 6'b001000;
        cyc();
        bus.release_pulse = '0;
        bus.cordic_rot_done = 1'b1;
        #1;
        n_total++;
        if ({bus.vec_done_out, bus.rot_done_out} !== 12'd0) begin
            n_bad++;
            $display("FAIL holdoff_done_drop vec=%b rot=%b want 0", bus.vec_done_out, bus.rot_done_out);
        end
        bus.cordic_rot_done = 1'b0;
        cyc();
        n_total++;
        if (bus.grant !== 6'b001000) begin
            n_bad++;
            $display("FAIL sole_requester_regrant grant=%b want 001000", bus.grant);
        end
    endtask

    // variant 0: plain timeout, 1: release in the timeout cycle, 2: done in it
    task automatic test_timeout(input int variant);
        do_reset();
        bus.req = 6'b000100;
        cyc();
        bus.req = '0;
        for (int c = 1; c < TO; c++) begin
            cyc();
            n_total++;
            if (bus.grant !== 6'b000100 || bus.timeout_err !== 1'b0) begin
                n_bad++;
                $display("FAIL wd_hold v=%0d c=%0d grant=%b terr=%b want 000100/0", variant, c, bus.grant, bus.timeout_err);
            end
        end
        if (variant == 1) bus.release_pulse = 6'b000100;
        if (variant == 2) bus.cordic_vec_done = 1'b1;
        cyc();
        bus.release_pulse = '0;
        bus.cordic_vec_done = 1'b0;
        n_total++;
        case (variant)
            0: if ({bus.timeout_err, bus.timeout_client, bus.grant} !== {1'b1, 3'd2, 6'd0}) begin
                   n_bad++;
                   $display("FAIL timeout_fire terr=%b client=%0d grant=%b want 1/2/0",
                            bus.timeout_err, bus.timeout_client, bus.grant);
               end
            1: if ({bus.timeout_err, bus.grant} !== {1'b0, 6'd0}) begin
                   n_bad++;
                   $display("FAIL release_beats_timeout terr=%b grant=%b want 0/0", bus.timeout_err, bus.grant);
               end
            default: if ({bus.timeout_err, bus.grant} !== {1'b0, 6'b000100}) begin
                   n_bad++;
                   $display("FAIL done_beats_timeout terr=%b grant=%b want 0/000100", bus.timeout_err, bus.grant);
               end
        endcase
        if (variant == 0) begin
            cyc();
            n_total++;
            if ({bus.timeout_err, bus.timeout_client} !== {1'b0, 3'd2}) begin
                n_bad++;
                $display("FAIL timeout_pulse_width terr=%b client=%0d want 0/2", bus.timeout_err, bus.timeout_client);
            end
        end
    endtask

    task automatic test_en_gate_and_async_reset();
        do_reset();
        bus.en  = 1'b0;
        bus.req = 6'b000100;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_total++;
            if (bus.grant !== 6'd0) begin
                n_bad++;
                $display("FAIL en_low_no_grant c=%0d grant=%b want 0", c, bus.grant);
            end
        end
        bus.en = 1'b1;
        cyc();
        n_total++;
        if (bus.grant !== 6'b000100) begin
            n_bad++;
            $display("FAIL en_rise_grant grant=%b want 000100", bus.grant);
        end
        #2;
        nrst = 1'b0;
        #1;
        n_total++;
        if ({bus.grant, bus.block, bus.mux_en, bus.busy} !== 11'd0) begin
            n_bad++;
            $display("FAIL async_reset grant=%b block=%0d mux_en=%b busy=%b want 0",
                     bus.grant, bus.block, bus.mux_en, bus.busy);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [5:0] eg;
            bus.en              = ($urandom_range(0, 4) != 0);
            bus.req             = 6'($urandom);
            bus.release_pulse   = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
            bus.cordic_vec_done = ($urandom_range(0, 15) == 0);
            bus.cordic_rot_done = ($urandom_range(0, 15) == 0);
            #1;
            eg = exp_grant();
            n_total++;
            if ({bus.grant, bus.block, bus.mux_en, bus.busy} !==
                {eg, 3'(m_block), eg != 0, eg != 0}) begin
                n_bad++;
                $display("FAIL rand_grant i=%0d grant=%b block=%0d mux_en=%b busy=%b want %b/%0d",
                         i, bus.grant, bus.block, bus.mux_en, bus.busy, eg, m_block);
            end
            n_total++;
            if ({bus.timeout_err, bus.timeout_client} !== {m_terr, 3'(m_tc)}) begin
                n_bad++;
                $display("FAIL rand_timeout i=%0d terr=%b client=%0d want %b/%0d",
                         i, bus.timeout_err, bus.timeout_client, m_terr, m_tc);
            end
            n_total++;
            if ({bus.vec_done_out, bus.rot_done_out} !==
                {eg & {6{bus.cordic_vec_done}}, eg & {6{bus.cordic_rot_done}}}) begin
                n_bad++;
                $display("FAIL rand_done_route i=%0d vec=%b rot=%b owner=%0d",
                         i, bus.vec_done_out, bus.rot_done_out, m_owner);
            end
            n_total++;
            if ($countones(bus.grant) > 1) begin
                n_bad++;
                $display("FAIL rand_onehot i=%0d grant=%b want at most one bit", i, bus.grant);
            end
            cyc();
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_first_grant();
        test_release_handover();
        test_round_robin();
        test_done_routing();
        test_timeout(0);
        test_timeout(1);
        test_timeout(2);
        test_en_gate_and_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
